l2_dir: RTL

- Directory-side controller for the PMESH coherence model. It is the other end of the L1.5 protocol.
- Consumes L1 requests on msg1 and L1 responses on msg3. Produces grants and forwards on msg2, plus the granted state on mesi_send.
- An external-agent request port models a second sharer, so that forward and invalidate flows are exercised.
- Paired with the L1.5 block for closed-loop equivalence checking.

---
 rtl/l2_dir_pkg.sv | 33 +++
 rtl/l2_dir_array.sv | 50 +++++
 rtl/l2_dir.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/l2_dir_pkg.sv
// l2_dir_pkg: message/MESI encodings, default widths and small helpers for the L2 directory.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package l2_dir_pkg;

  localparam int CCP_DATA_WIDTH = 8;
  localparam int CCP_TAG_WIDTH  = 2;
  localparam int CCP_MSG_WIDTH  = 4;
  localparam int CCP_MESI_WIDTH = 2;

  localparam logic [CCP_MSG_WIDTH-1:0] MSG_NONE          = 4'd0;
  localparam logic [CCP_MSG_WIDTH-1:0] MSG_LOAD_REQ      = 4'd1;
  localparam logic [CCP_MSG_WIDTH-1:0] MSG_STORE_REQ     = 4'd2;
  localparam logic [CCP_MSG_WIDTH-1:0] MSG_WB_REQ        = 4'd3;
  localparam logic [CCP_MSG_WIDTH-1:0] MSG_DATA_ACK      = 4'd4;
  localparam logic [CCP_MSG_WIDTH-1:0] MSG_INV_FWD       = 4'd5;
  localparam logic [CCP_MSG_WIDTH-1:0] MSG_LOAD_FWD      = 4'd6;
  localparam logic [CCP_MSG_WIDTH-1:0] MSG_STORE_FWD     = 4'd7;
  localparam logic [CCP_MSG_WIDTH-1:0] MSG_INV_ACK       = 4'd8;
  localparam logic [CCP_MSG_WIDTH-1:0] MSG_LOAD_FWD_ACK  = 4'd9;
  localparam logic [CCP_MSG_WIDTH-1:0] MSG_STORE_FWD_ACK = 4'd10;

  localparam logic [CCP_MESI_WIDTH-1:0] MESI_I = 2'd0;
  localparam logic [CCP_MESI_WIDTH-1:0] MESI_S = 2'd1;
  localparam logic [CCP_MESI_WIDTH-1:0] MESI_E = 2'd2;
  localparam logic [CCP_MESI_WIDTH-1:0] MESI_M = 2'd3;

  // E and M both have the MSB set: the L1 owns the line exclusively.
  function automatic logic is_excl(input logic [CCP_MESI_WIDTH-1:0] st);
    return st[1];
  endfunction

endpackage

// File: rtl/l2_dir_array.sv
// l2_dir_array: per-tag directory storage (data word, L1 MESI state, external-sharer bit).
// Latency: combinational read; write takes effect at the next clk edge.
// Backpressure: none, one write per cycle always accepted.
// Ports: clk/rst (async, active-high); we/waddr/wdata/wdir/wsh write port;
//        raddr -> rdata/rdir/rsh read port.
module l2_dir_array
  import l2_dir_pkg::*;
#(
  parameter int DATA_WIDTH = CCP_DATA_WIDTH,
  parameter int TAG_WIDTH  = CCP_TAG_WIDTH,
  parameter int MESI_WIDTH = CCP_MESI_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [TAG_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [MESI_WIDTH-1:0] wdir,
  input  logic                  wsh,
  input  logic [TAG_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [MESI_WIDTH-1:0] rdir,
  output logic                  rsh
);

  localparam int DEPTH = 1 << TAG_WIDTH;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [MESI_WIDTH-1:0] dir_mem  [DEPTH];
  logic [DEPTH-1:0]      sh_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        dir_mem[i]  <= '0;  // I
      end
      sh_mem <= '0;
    end else if (we) begin
      data_mem[waddr] <= wdata;
      dir_mem[waddr]  <= wdir;
      sh_mem[waddr]   <= wsh;
    end
  end

  assign rdata = data_mem[raddr];
  assign rdir  = dir_mem[raddr];
  assign rsh   = sh_mem[raddr];

endmodule

// File: rtl/l2_dir.sv
// l2_dir: directory controller for the L1.5; grants L1 requests and forwards/invalidates for an external sharer.
// Latency: DATA_ACK one cycle after msg1; ext_done one cycle after a local ext op or after the matching msg3 ack.
// Backpressure: msg1 is not consumed outside IDLE (the L1 holds it); ext_req is held until ext_done.
// Ports: clk, rst (async, active-high); msg1_* L1 requests; msg3_* L1 responses; ext_* external agent;
//        msg2_* / mesi_send registered one-cycle messages; err (only with CCP_L2_ERR_CHK_EN, sticky protocol error).
module l2_dir
  import l2_dir_pkg::*;
#(
  parameter int DATA_WIDTH = CCP_DATA_WIDTH,
  parameter int TAG_WIDTH  = CCP_TAG_WIDTH,
  parameter int MSG_WIDTH  = CCP_MSG_WIDTH,
  parameter int MESI_WIDTH = CCP_MESI_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MSG_WIDTH-1:0]  msg1_type,
  input  logic [DATA_WIDTH-1:0] msg1_data,
  input  logic [TAG_WIDTH-1:0]  msg1_tag,
  input  logic [MSG_WIDTH-1:0]  msg3_type,
  input  logic [DATA_WIDTH-1:0] msg3_data,
  input  logic [TAG_WIDTH-1:0]  msg3_tag,
  input  logic                  ext_req,
  input  logic                  ext_store,
  input  logic [TAG_WIDTH-1:0]  ext_tag,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic [MSG_WIDTH-1:0]  msg2_type,
  output logic [DATA_WIDTH-1:0] msg2_data,
  output logic [TAG_WIDTH-1:0]  msg2_tag,
  output logic [MESI_WIDTH-1:0] mesi_send,
  output logic                  ext_done,
  output logic [DATA_WIDTH-1:0] ext_rdata
`ifdef CCP_L2_ERR_CHK_EN
  ,
  output logic                  err
`endif
);

  typedef enum logic [1:0] {IDLE, FWD_WAIT, INV_WAIT} state_t;

  state_t                state;
  logic [TAG_WIDTH-1:0]  wait_tag;
  logic                  wait_store;

  logic                  we;
  logic [TAG_WIDTH-1:0]  raddr, waddr;
  logic [DATA_WIDTH-1:0] rdata, wdata;
  logic [MESI_WIDTH-1:0] rdir, wdir, load_grant;
  logic                  rsh, wsh;
  logic                  msg1_vld, ext_local, ack_ok;
  logic [MSG_WIDTH-1:0]  ack_type;

  // msg1 has priority in IDLE, so it also owns the single read port when present.
  assign msg1_vld   = (msg1_type != MSG_NONE);
  assign raddr      = msg1_vld ? msg1_tag : ext_tag;
  assign load_grant = is_excl(rdir) ? rdir : (rsh ? MESI_S : MESI_E);
  // External op finishes without the L1 unless the L1 owns the line or a store must kill an L1 copy.
  assign ext_local  = !is_excl(rdir) && !((rdir == MESI_S) && ext_store);

  always_comb begin
    ack_type = MSG_INV_ACK;
    if (state == FWD_WAIT) ack_type = wait_store ? MSG_STORE_FWD_ACK : MSG_LOAD_FWD_ACK;
  end
  assign ack_ok = (state != IDLE) && (msg3_type == ack_type) && (msg3_tag == wait_tag);

  // Entry update: default rewrites the entry that was read, so only changed fields are set.
  always_comb begin
    we    = 1'b0;
    waddr = raddr;
    wdata = rdata;
    wdir  = rdir;
    wsh   = rsh;
    if (state == IDLE) begin
      if (msg1_vld) begin
        case (msg1_type)
          MSG_LOAD_REQ:  begin we = 1'b1; wdir = load_grant; end
          MSG_STORE_REQ: begin we = 1'b1; wdir = MESI_M; wsh = 1'b0; end
          MSG_WB_REQ:    begin we = 1'b1; wdir = MESI_I; wdata = msg1_data; end
          default: ;
        endcase
      end else if (ext_req && ext_local) begin
        we  = 1'b1;
        wsh = 1'b1;
        if (ext_store) wdata = ext_wdata;
      end
    end else if (ack_ok) begin
      we    = 1'b1;
      waddr = wait_tag;
      wsh   = 1'b1;
      if ((state == FWD_WAIT) && !wait_store) begin
        wdata = msg3_data;
        wdir  = MESI_S;
      end else begin
        wdata = ext_wdata;
        wdir  = MESI_I;
      end
    end
  end

  l2_dir_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .MESI_WIDTH (MESI_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .wdir  (wdir),
    .wsh   (wsh),
    .raddr (raddr),
    .rdata (rdata),
    .rdir  (rdir),
    .rsh   (rsh)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_tag   <= '0;
      wait_store <= 1'b0;
      msg2_type  <= MSG_NONE;
      msg2_data  <= '0;
      msg2_tag   <= '0;
      mesi_send  <= MESI_I;
      ext_done   <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      msg2_type <= MSG_NONE;
      msg2_data <= '0;
      msg2_tag  <= '0;
      mesi_send <= MESI_I;
      ext_done  <= 1'b0;
      ext_rdata <= '0;
      case (state)
        IDLE: begin
          if (msg1_vld) begin
            if ((msg1_type == MSG_LOAD_REQ) || (msg1_type == MSG_STORE_REQ) ||
                (msg1_type == MSG_WB_REQ)) begin
              msg2_type <= MSG_DATA_ACK;
              msg2_tag  <= msg1_tag;
              msg2_data <= wdata;
              mesi_send <= wdir;
            end
          end else if (ext_req) begin
            if (ext_local) begin
              ext_done  <= 1'b1;
              ext_rdata <= wdata;
            end else begin
              wait_tag   <= ext_tag;
              wait_store <= ext_store;
              msg2_tag   <= ext_tag;
              if (is_excl(rdir)) begin
                msg2_type <= ext_store ? MSG_STORE_FWD : MSG_LOAD_FWD;
                state     <= FWD_WAIT;
              end else begin
                msg2_type <= MSG_INV_FWD;
                state     <= INV_WAIT;
              end
            end
          end
        end
        default: begin
          if (ack_ok) begin
            ext_done  <= 1'b1;
            ext_rdata <= wdata;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef CCP_L2_ERR_CHK_EN
  logic err_set;
  always_comb begin
    err_set = (msg1_type > MSG_WB_REQ) ||
              !((msg3_type == MSG_NONE) || (msg3_type == MSG_INV_ACK) ||
                (msg3_type == MSG_LOAD_FWD_ACK) || (msg3_type == MSG_STORE_FWD_ACK));
    if (state == IDLE) begin
      if (msg3_type != MSG_NONE) err_set = 1'b1;
      if (((msg1_type == MSG_LOAD_REQ) || (msg1_type == MSG_STORE_REQ)) && is_excl(rdir))
        err_set = 1'b1;
    end else if ((msg3_type != MSG_NONE) && !ack_ok) begin
      err_set = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end
`endif

endmodule
